// File: rtl/timer_irq_pkg.sv
// Shared definitions for the timer interrupt generator.
// Holds the channel mode encodings, the default parameter widths and the
// overrun counter width.
package timer_irq_pkg;

    localparam int unsigned DEF_NUM_CH = 15;
    localparam int unsigned DEF_CNT_W  = 24;
    localparam int unsigned DEF_HOLD_W = 12;
    localparam int unsigned OVR_CNT_W  = 8;

    typedef enum logic [1:0] {
        MODE_PULSE   = 2'd0,
        MODE_ONESHOT = 2'd1,
        MODE_LEVEL   = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

endpackage

// File: rtl/timer_irq_ch.sv
// One timer channel: period counter, pulse-width hold, one-shot latch and
// level-ack interrupt.
// Overrun detection is compiled in only when TIMER_IRQ_OVERRUN_EN is defined.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   en_i         - channel enable
//   mode_i       - mode (pulse / one-shot / level-ack; reserved acts as pulse)
//   period_i     - period in cycles (0 = never expires)
//   width_i      - pulse width in cycles (0 acts as 1)
//   ack_i        - level-ack acknowledge
//   irq_o        - registered interrupt
//   irq_nxt_c    - combinational next value of irq_o (feeds irq_any)
//   ovr_o        - overrun pulse           (TIMER_IRQ_OVERRUN_EN only)
//   ovr_cnt_o    - saturating overrun count (TIMER_IRQ_OVERRUN_EN only)
module timer_irq_ch
    import timer_irq_pkg::*;
#(
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned HOLD_W = DEF_HOLD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [1:0]        mode_i,
    input  logic [CNT_W-1:0]  period_i,
    input  logic [HOLD_W-1:0] width_i,
    input  logic              ack_i,
    output logic              irq_o,
    output logic              irq_nxt_c
`ifdef TIMER_IRQ_OVERRUN_EN
    ,
    output logic                 ovr_o,
    output logic [OVR_CNT_W-1:0] ovr_cnt_o
`endif
);

    logic              en_q;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic [CNT_W-1:0]  per_q,  per_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              irq_q,  irq_d;
    logic              done_q, done_d;
    logic              expire_c;
    mode_e             mode_c;

    // Reserved encoding behaves as periodic pulse.
    always_comb begin
        mode_c = mode_e'(mode_i);
        if (mode_c == MODE_RSVD) begin
            mode_c = MODE_PULSE;
        end
    end

    // Expiry only in steady enabled state; a zero period never expires.
    assign expire_c = en_i && en_q && !done_q && (per_q != '0)
                      && (cnt_q == per_q - CNT_W'(1));

    // Next-state logic for counter, sampled period, hold count and irq.
    always_comb begin
        cnt_d  = cnt_q;
        per_d  = per_q;
        hold_d = hold_q;
        irq_d  = irq_q;
        done_d = done_q;
        if (!en_i) begin
            cnt_d  = '0;
            per_d  = '0;
            hold_d = '0;
            irq_d  = 1'b0;
            done_d = 1'b0;
        end else if (!en_q) begin
            // Enable rising edge: arm with a fresh period.
            cnt_d = '0;
            per_d = period_i;
        end else begin
            if (expire_c) begin
                cnt_d = '0;
                per_d = period_i;
            end else if ((per_q != '0) && !done_q) begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            if (mode_c == MODE_LEVEL) begin
                // Set wins over a coincident acknowledge.
                if (expire_c) begin
                    irq_d = 1'b1;
                end else if (ack_i) begin
                    irq_d = 1'b0;
                end
            end else if (expire_c) begin
                // hold counts the remaining high cycles after this one.
                irq_d  = 1'b1;
                hold_d = (width_i == '0) ? '0 : width_i - HOLD_W'(1);
                if (mode_c == MODE_ONESHOT) begin
                    done_d = 1'b1;
                end
            end else if (irq_q) begin
                if (hold_q == '0) begin
                    irq_d = 1'b0;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            cnt_q  <= '0;
            per_q  <= '0;
            hold_q <= '0;
            irq_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            en_q   <= en_i;
            cnt_q  <= cnt_d;
            per_q  <= per_d;
            hold_q <= hold_d;
            irq_q  <= irq_d;
            done_q <= done_d;
        end
    end

    assign irq_o     = irq_q;
    assign irq_nxt_c = irq_d;

`ifdef TIMER_IRQ_OVERRUN_EN
    logic                 ovr_q,     ovr_d;
    logic [OVR_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;

    // Overrun: level-ack channel expires while its irq is still pending.
    always_comb begin
        ovr_d     = expire_c && (mode_c == MODE_LEVEL) && irq_q;
        ovr_cnt_d = ovr_cnt_q;
        if (!en_i) begin
            ovr_cnt_d = '0;
        end else if (ovr_d && (ovr_cnt_q != '1)) begin
            ovr_cnt_d = ovr_cnt_q + OVR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q     <= 1'b0;
            ovr_cnt_q <= '0;
        end else begin
            ovr_q     <= ovr_d;
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign ovr_o     = ovr_q;
    assign ovr_cnt_o = ovr_cnt_q;
`endif

endmodule

// File: rtl/timer_irq_gen.sv
// Multi-channel timer interrupt generator: NUM_CH independent timer_irq_ch
// channels plus a registered OR of all interrupt lines.
// Optional overrun reporting is enabled with TIMER_IRQ_OVERRUN_EN.
// Ports:
//   clk_100, rst_100 - clock, asynchronous active-low reset
//   ch_en            - per-channel enable
//   ch_mode          - 2 bits per channel mode
//   ch_period        - CNT_W bits per channel period
//   ch_width         - HOLD_W bits per channel pulse width
//   irq_ack          - per-channel level-ack acknowledge
//   irq              - registered interrupt lines
//   irq_any          - registered OR of irq, aligned with irq
//   irq_ovr          - overrun pulses           (TIMER_IRQ_OVERRUN_EN only)
//   irq_ovr_cnt      - 8 bits per channel count (TIMER_IRQ_OVERRUN_EN only)
module timer_irq_gen
    import timer_irq_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned HOLD_W = DEF_HOLD_W
) (
    input  logic                     clk_100,
    input  logic                     rst_100,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [2*NUM_CH-1:0]      ch_mode,
    input  logic [CNT_W*NUM_CH-1:0]  ch_period,
    input  logic [HOLD_W*NUM_CH-1:0] ch_width,
    input  logic [NUM_CH-1:0]        irq_ack,
    output logic [NUM_CH-1:0]        irq,
    output logic                     irq_any
`ifdef TIMER_IRQ_OVERRUN_EN
    ,
    output logic [NUM_CH-1:0]           irq_ovr,
    output logic [OVR_CNT_W*NUM_CH-1:0] irq_ovr_cnt
`endif
);

    logic [NUM_CH-1:0] irq_nxt;
    logic              irq_any_q;

    // One channel instance per timer.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_irq_ch #(
            .CNT_W  (CNT_W),
            .HOLD_W (HOLD_W)
        ) u_ch (
            .clk       (clk_100),
            .rst_n     (rst_100),
            .en_i      (ch_en[i]),
            .mode_i    (ch_mode[2*i +: 2]),
            .period_i  (ch_period[CNT_W*i +: CNT_W]),
            .width_i   (ch_width[HOLD_W*i +: HOLD_W]),
            .ack_i     (irq_ack[i]),
            .irq_o     (irq[i]),
            .irq_nxt_c (irq_nxt[i])
`ifdef TIMER_IRQ_OVERRUN_EN
            ,
            .ovr_o     (irq_ovr[i]),
            .ovr_cnt_o (irq_ovr_cnt[OVR_CNT_W*i +: OVR_CNT_W])
`endif
        );
    end

    // OR of next-state irq values so irq_any lines up with irq.
    always_ff @(posedge clk_100 or negedge rst_100) begin
        if (!rst_100) begin
            irq_any_q <= 1'b0;
        end else begin
            irq_any_q <= |irq_nxt;
        end
    end

    assign irq_any = irq_any_q;

endmodule

// File: doc/timer_irq_gen.md
TIMER_IRQ_GEN -- requirements
Module: timer_irq_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 15: number of independent timer channels, 1..32.
REQ-002 SHALL have parameter CNT_W, default 24: period counter width per channel.
REQ-003 SHALL have parameter HOLD_W, default 12: pulse-width counter width per channel.
REQ-004 SHALL have port clk_100  input  1: single clock, 100 MHz nominal.
REQ-005 SHALL have port rst_100  input  1: asynchronous, active-low reset; asserted when low.
REQ-006 SHALL have port ch_en  input  NUM_CH: per-channel enable.
REQ-007 SHALL have port ch_mode  input  2*NUM_CH: per-channel mode; 0 periodic-pulse, 1 one-shot, 2 level-ack, 3 reserved (treated as 0).
REQ-008 SHALL have port ch_period  input  CNT_W*NUM_CH: per-channel period in cycles.
REQ-009 SHALL have port ch_width  input  HOLD_W*NUM_CH: per-channel pulse width in cycles.
REQ-010 SHALL have port irq_ack  input  NUM_CH: single-cycle acknowledge, level-ack mode only.
REQ-011 SHALL have port irq  output  NUM_CH: registered interrupt lines.
REQ-012 SHALL have port irq_any  output  1: registered OR of irq.

Function
REQ-013 Channel disabled (ch_en low): counter held 0, irq low on next edge, one-shot done flag cleared.
REQ-014 Period P sampled at enable rising edge and at every expiry; mid-period changes take effect next period only.
REQ-015 Expiry = counter equals P-1; counter wraps to 0 same edge; P=0 means no expiry ever; P=1 expires every cycle.
REQ-016 Latency: first irq rise at the P-th edge after the edge that first samples ch_en high; then one expiry every P cycles.
REQ-017 Periodic-pulse: irq high for W cycles after each expiry; W=0 treated as 1; expiry while irq high restarts the width count (W>=P gives constant high).
REQ-018 One-shot: identical to periodic-pulse for the first expiry only; then counter stops and irq follows REQ-017 to completion; re-arm requires ch_en low for at least one cycle.
REQ-019 Level-ack: irq set on expiry, cleared on the edge after irq_ack sampled high; ack with irq low ignored.
REQ-020 Level-ack: ack and expiry on the same edge leave irq high (set wins).
REQ-021 ch_mode change while enabled: undefined irq for at most one pulse; software shall disable first.
REQ-022 irq_any equals OR of irq in the same cycle (computed from next-state values, no extra cycle).

Reset
REQ-023 On rst_100 low: all counters, sampled periods, done flags, irq and irq_any 0, asynchronously.
REQ-024 After rst_100 release, channels already enabled behave as if ch_en rose at the first sampling edge.

Configuration
REQ-025 With TIMER_IRQ_OVERRUN_EN defined: output irq_ovr (NUM_CH) pulses 1 cycle when a level-ack channel expires while irq already high; output irq_ovr_cnt (8*NUM_CH) saturating per-channel overrun count, cleared by disable.
REQ-026 Without TIMER_IRQ_OVERRUN_EN: neither port exists, no overrun logic synthesised.

Structure
REQ-027 Package timer_irq_pkg SHALL hold mode encodings (MODE_PULSE, MODE_ONESHOT, MODE_LEVEL) and default widths.
REQ-028 Per-channel logic SHALL be sub-module timer_irq_ch, instantiated NUM_CH times by generate; top holds only slicing and irq_any.

Verification
REQ-029 NUM_CH=2, ch0 pulse P=10 W=3 -> irq[0] high cycles 10-12, 20-22, 30-32 after enable; irq[1] low.
REQ-030 One-shot P=5 W=2 -> single pulse cycles 5-6, none over 100 cycles; ch_en low 1 cycle then high -> new pulse 5 cycles later.
REQ-031 Level-ack P=8, ack at cycle 12 -> irq high 8-12, low 13; ack coincident with expiry at 16 -> irq stays high.
REQ-032 Pulse P=4 W=6 -> irq constant high from cycle 4; P=0 -> irq never rises.
REQ-033 Reset asserted mid-pulse (P=10 W=5, reset at cycle 12) -> irq and irq_any 0 immediately without clock edge; restart after release.
REQ-034 TIMER_IRQ_OVERRUN_EN, level-ack P=4, no ack for 20 cycles -> irq_ovr pulses at 8,12,16,20; irq_ovr_cnt=4.
